// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer
// Sequences an optional writeback followed by two operand reads onto a
// single-port register file. The register file has one address bus and a
// shared bidirectional data bus. Both operands are returned on a valid/ready
// response channel.
// Optional build macro: RF_SEQ_READ_MERGE_EN. When it is defined and
// rs1 == rs2, the second read is skipped and the rs1 capture is reused.
module rf_access_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs1_data,
  output logic [DATA_W-1:0] rsp_rs2_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic              rf_enable,
  inout  wire  [DATA_W-1:0] rf_data
);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RSP} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_bus;
  logic              accept;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  // Accept is taken from the registered state only, never from req_ready.
  assign accept = req_valid && (state_q == IDLE);

  // x0 always reads as zero, whatever the register file puts on the bus.
  assign rs1_val = (rs1_q == '0) ? '0 : rf_data;
  assign rs2_val = (rs2_q == '0) ? '0 : rf_data;

  // The sequencer owns the bus only in WR; the register file only drives it
  // in RD1/RD2, so both sides are decoded from the same registered state.
  assign rf_data = drive_bus ? wdata_q : {DATA_W{1'bz}};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latch the request on the accepting edge; later req_* changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rs1_q   <= req_rs1;
      rs2_q   <= req_rs2;
      rd_q    <= req_rd;
      wdata_q <= req_wdata;
    end
  end

  // Capture operands at the closing edge of each read state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else if (state_q == RD1) begin
      rsp_rs1_data <= rs1_val;
`ifdef RF_SEQ_READ_MERGE_EN
      if (rs1_q == rs2_q) rsp_rs2_data <= rs1_val;
`endif
    end else if (state_q == RD2) begin
      rsp_rs2_data <= rs2_val;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_addr   = '0;
    rf_we     = 1'b0;
    rf_enable = 1'b0;
    drive_bus = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        // Writes to x0 are dropped here so they never reach the bus.
        if (req_valid) state_d = (req_wen && (req_rd != '0)) ? WR : RD1;
      end
      WR: begin
        rf_addr   = rd_q;
        rf_we     = 1'b1;
        drive_bus = 1'b1;
        state_d   = RD1;
      end
      RD1: begin
        rf_addr   = rs1_q;
        rf_enable = 1'b1;
`ifdef RF_SEQ_READ_MERGE_EN
        state_d   = (rs1_q == rs2_q) ? RSP : RD2;
`else
        state_d   = RD2;
`endif
      end
      RD2: begin
        rf_addr   = rs2_q;
        rf_enable = 1'b1;
        state_d   = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
